// File: rtl/cva6_ptw_sv32_walker_pkg.sv
// Shared types for the Sv32 page-table walker: PTE layout, FSM states, TLB update header.
package cva6_ptw_sv32_pkg;

   localparam int unsigned PTE_SIZE_LOG2 = 2;
   localparam int unsigned VPN_W         = 20;
   localparam int unsigned PPN_W         = 22;
   localparam int unsigned PADDR_W       = 34;

   typedef struct packed {
      logic [11:0] ppn1;
      logic [9:0]  ppn0;
      logic [1:0]  rsw;
      logic        d;
      logic        a;
      logic        g;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        v;
   } pte_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_L1_REQ,
      S_L1_WAIT,
      S_L0_REQ,
      S_L0_WAIT,
      S_DONE,
      S_FAULT,
      S_DRAIN
   } ptw_state_e;

   // Leading fields of update_o; the ASID and PTE follow in the packed output.
   typedef struct packed {
      logic             valid;
      logic             is_4m;
      logic [VPN_W-1:0] vpn;
   } tlb_update_t;

endpackage

// File: rtl/cva6_ptw_sv32_walker_if.sv
// One-outstanding PTE read port between the walker (master) and the memory arbiter (slave).
interface cva6_ptw_sv32_walker_if;
   import cva6_ptw_sv32_pkg::*;

   logic               mem_req_valid;
   logic               mem_req_ready;
   logic [PADDR_W-1:0] mem_req_addr;
   logic               mem_rsp_valid;
   logic [31:0]        mem_rsp_data;

   modport master (
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data
   );

   modport slave (
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data
   );
endinterface

// File: rtl/cva6_ptw_sv32_walker_pte_check.sv
// Combinational Sv32 PTE classification for the level currently being walked.
module ptw_sv32_pte_check
   import cva6_ptw_sv32_pkg::*;
(
   input  pte_t pte_i,
   input  logic level1_i,
   output logic invalid_o,
   output logic leaf_o,
   output logic misaligned_o
);

   logic unused_fields;

   assign invalid_o     = !pte_i.v || (!pte_i.r && pte_i.w);
   assign leaf_o        = pte_i.r || pte_i.x;
   // A 4M superpage must have its low PPN field clear.
   assign misaligned_o  = level1_i && leaf_o && (pte_i.ppn0 != '0);
   assign unused_fields = ^{pte_i.ppn1, pte_i.rsw, pte_i.d, pte_i.a, pte_i.g, pte_i.u};

endmodule

// File: rtl/cva6_ptw_sv32_walker.sv
// Sv32 page-table walker: two-level PTE fetch, emits a one-cycle TLB update or page fault.
module cva6_ptw_sv32_walker
   import cva6_ptw_sv32_pkg::*;
#(
   parameter int unsigned ASID_WIDTH = 9
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic [PPN_W-1:0]        satp_ppn_i,
   input  logic                    walk_valid_i,
   output logic                    walk_ready_o,
   input  logic [31:0]             walk_vaddr_i,
   input  logic [ASID_WIDTH-1:0]   walk_asid_i,
   cva6_ptw_sv32_walker_if.master  mem,
   output logic [54+ASID_WIDTH-1:0] update_o,
   output logic                    walk_fault_o,
   output logic                    busy_o
);

   ptw_state_e                state_q, state_d;
   logic [VPN_W-1:0]          vpn_q, vpn_d;
   logic [ASID_WIDTH-1:0]     asid_q, asid_d;
   logic [PPN_W-1:0]          ppn_q, ppn_d;
   logic [54+ASID_WIDTH-1:0]  upd_q, upd_d;
   logic                      fault_q, fault_d;

   pte_t        rsp_pte;
   tlb_update_t hdr;
   logic        chk_invalid, chk_leaf, chk_misaligned;
   logic        unused_vaddr;

   assign rsp_pte      = pte_t'(mem.mem_rsp_data);
   assign unused_vaddr = ^walk_vaddr_i[11:0];

   ptw_sv32_pte_check i_pte_check (
      .pte_i        (rsp_pte),
      .level1_i     (state_q == S_L1_WAIT),
      .invalid_o    (chk_invalid),
      .leaf_o       (chk_leaf),
      .misaligned_o (chk_misaligned)
   );

   assign walk_ready_o  = (state_q == S_IDLE) && !flush_i;
   assign busy_o        = (state_q != S_IDLE);
   assign update_o      = upd_q;
   assign walk_fault_o  = fault_q;
   // A flush in a request state drops the request, so valid is withheld even if ready is high.
   assign mem.mem_req_valid = ((state_q == S_L1_REQ) || (state_q == S_L0_REQ)) && !flush_i;
   assign mem.mem_req_addr  = (state_q == S_L0_REQ)
                            ? {ppn_q, vpn_q[9:0], {PTE_SIZE_LOG2{1'b0}}}
                            : {satp_ppn_i, vpn_q[19:10], {PTE_SIZE_LOG2{1'b0}}};

   always_comb begin
      state_d = state_q;
      vpn_d   = vpn_q;
      asid_d  = asid_q;
      ppn_d   = ppn_q;
      upd_d   = '0;
      fault_d = 1'b0;
      hdr     = '0;
      unique case (state_q)
         S_IDLE: begin
            if (walk_valid_i && walk_ready_o) begin
               vpn_d   = walk_vaddr_i[31:12];
               asid_d  = walk_asid_i;
               state_d = S_L1_REQ;
            end
         end
         S_L1_REQ, S_L0_REQ: begin
            if (flush_i) state_d = S_IDLE;
            else if (mem.mem_req_ready) state_d = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
         end
         S_L1_WAIT, S_L0_WAIT: begin
            // A response coinciding with the flush is the one DRAIN would wait for, so skip DRAIN.
            if (mem.mem_rsp_valid) begin
               if (flush_i) begin
                  state_d = S_IDLE;
               end else if (chk_invalid || chk_misaligned || (state_q == S_L0_WAIT && !chk_leaf)) begin
                  state_d = S_FAULT;
                  fault_d = 1'b1;
               end else if (chk_leaf) begin
                  state_d   = S_DONE;
                  hdr.valid = 1'b1;
                  hdr.is_4m = (state_q == S_L1_WAIT);
                  hdr.vpn   = vpn_q;
                  upd_d     = {hdr, asid_q, mem.mem_rsp_data};
               end else begin
                  ppn_d   = {rsp_pte.ppn1, rsp_pte.ppn0};
                  state_d = S_L0_REQ;
               end
            end else if (flush_i) begin
               state_d = S_DRAIN;
            end
         end
         S_DONE, S_FAULT: state_d = S_IDLE;
         S_DRAIN: if (mem.mem_rsp_valid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         vpn_q   <= '0;
         asid_q  <= '0;
         ppn_q   <= '0;
         upd_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vpn_q   <= vpn_d;
         asid_q  <= asid_d;
         ppn_q   <= ppn_d;
         upd_q   <= upd_d;
         fault_q <= fault_d;
      end
   end

endmodule

// File: tb/tb_cva6_ptw_sv32_walker.sv
// Directed bench for the Sv32 walker: a task-driven memory responder and hand-computed outcomes.
module tb_cva6_ptw_sv32_walker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [21:0] satp = 22'h00010;
   logic        wv = 1'b0;
   logic        wr;
   logic [31:0] va = '0;
   logic [8:0]  asid = '0;
   logic [62:0] upd;
   logic        flt;
   logic        busy;

   cva6_ptw_sv32_walker_if mem_if();

   cva6_ptw_sv32_walker #(.ASID_WIDTH(9)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .flush_i      (flush),
      .satp_ppn_i   (satp),
      .walk_valid_i (wv),
      .walk_ready_o (wr),
      .walk_vaddr_i (va),
      .walk_asid_i  (asid),
      .mem          (mem_if),
      .update_o     (upd),
      .walk_fault_o (flt),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   int          r_nreq, r_nupd, r_upd_cyc, r_flt_cyc;
   logic [62:0] r_upd;
   logic [33:0] r_addr [2];
   bit          r_moved, r_to;

   // Accepts one walk, then answers each accepted request with the next PTE one cycle later.
   task automatic walk(input logic [31:0] v, input logic [8:0] a,
                       input logic [31:0] p1, input logic [31:0] p0, input int rdly);
      int          w;
      int          nrsp;
      bit          acc;
      bit          prev_wait;
      logic [33:0] prev_addr;
      r_nreq = 0; r_nupd = 0; r_upd_cyc = -1; r_flt_cyc = -1; r_upd = '0;
      r_addr[0] = '0; r_addr[1] = '0; r_moved = 1'b0; r_to = 1'b1;
      w = 0; nrsp = 0; acc = 1'b0; prev_wait = 1'b0; prev_addr = '0;
      @(negedge clk);
      wv = 1'b1; va = v; asid = a;
      #1 check("accept_ready", {63'd0, wr}, 64'd1);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         wv = 1'b0;
         mem_if.mem_req_ready = 1'b0;
         mem_if.mem_rsp_valid = acc;
         mem_if.mem_rsp_data  = (nrsp == 0) ? p1 : p0;
         if (acc) nrsp++;
         #1;
         if (upd[62]) begin r_nupd++; r_upd_cyc = cyc; r_upd = upd; end
         if (flt) r_flt_cyc = cyc;
         acc = 1'b0;
         if (mem_if.mem_req_valid) begin
            if (prev_wait && (mem_if.mem_req_addr !== prev_addr)) r_moved = 1'b1;
            mem_if.mem_req_ready = (w >= rdly);
            if (w >= rdly) begin
               acc = 1'b1;
               if (r_nreq < 2) r_addr[r_nreq] = mem_if.mem_req_addr;
               r_nreq++;
               w = 0;
               prev_wait = 1'b0;
            end else begin
               w++;
               prev_wait = 1'b1;
               prev_addr = mem_if.mem_req_addr;
            end
         end else begin
            prev_wait = 1'b0;
         end
         if (!busy) begin r_to = 1'b0; break; end
      end
      mem_if.mem_req_ready = 1'b0;
      mem_if.mem_rsp_valid = 1'b0;
      check("walk_timeout", {63'd0, r_to}, 64'd0);
   endtask

   task automatic check_walk(input string t, input int nreq, input logic [33:0] a0, input logic [33:0] a1,
                             input int ucyc, input logic [62:0] uval, input int fcyc);
      check({t, "_nreq"},  r_nreq,    nreq);
      check({t, "_addr0"}, r_addr[0], a0);
      check({t, "_addr1"}, r_addr[1], a1);
      check({t, "_nupd"},  r_nupd,    (ucyc >= 0) ? 1 : 0);
      check({t, "_ucyc"},  r_upd_cyc, ucyc);
      check({t, "_upd"},   r_upd,     uval);
      check({t, "_fcyc"},  r_flt_cyc, fcyc);
   endtask

   initial begin
      mem_if.mem_req_ready = 1'b0;
      mem_if.mem_rsp_valid = 1'b0;
      mem_if.mem_rsp_data  = '0;

      @(negedge clk);
      #1;
      check("rst_upd",   upd, 63'd0);
      check("rst_fault", flt, 1'b0);
      check("rst_memv",  mem_if.mem_req_valid, 1'b0);
      check("rst_busy",  busy, 1'b0);
      check("rst_ready", wr, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // 4K walk through a pointer PTE.
      walk(32'h4000_1000, 9'h005, 32'h0000_4C01, 32'h2000_00CF, 0);
      check_walk("w4k", 2, 34'h0_0001_0400, 34'h0_0001_3004, 5,
                 {1'b1, 1'b0, 20'h40001, 9'h005, 32'h2000_00CF}, -1);

      // Stray response while idle must not start or complete anything.
      @(negedge clk);
      mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_data = 32'h2000_00CF;
      #1 check("stray_busy", busy, 1'b0);
      @(negedge clk);
      mem_if.mem_rsp_valid = 1'b0;
      #1 check("stray_upd", upd, 63'd0);
      check("stray_busy2", busy, 1'b0);

      // Aligned 4M superpage, then back-to-back faults.
      walk(32'h00C0_3000, 9'h1FF, 32'h2000_00CF, 32'h0, 0);
      check_walk("w4m", 1, 34'h0_0001_000C, 34'h0, 3,
                 {1'b1, 1'b1, 20'h00C03, 9'h1FF, 32'h2000_00CF}, -1);
      walk(32'h4000_1000, 9'h005, 32'h2000_1CCF, 32'h0, 0);
      check_walk("misal", 1, 34'h0_0001_0400, 34'h0, -1, 63'd0, 3);
      walk(32'h4000_1000, 9'h005, 32'h0000_0004, 32'h0, 0);
      check_walk("inv_l1", 1, 34'h0_0001_0400, 34'h0, -1, 63'd0, 3);
      walk(32'h4000_1000, 9'h005, 32'h0000_4C01, 32'h0000_0001, 0);
      check_walk("nonleaf_l0", 2, 34'h0_0001_0400, 34'h0_0001_3004, -1, 63'd0, 5);

      // Memory stalls for four cycles; address must hold.
      walk(32'h4000_1000, 9'h005, 32'h2000_00CF, 32'h0, 4);
      check_walk("stall", 1, 34'h0_0001_0400, 34'h0, 7,
                 {1'b1, 1'b1, 20'h40001, 9'h005, 32'h2000_00CF}, -1);
      check("stall_addr_stable", {63'd0, r_moved}, 64'd0);

      // Flush while waiting for the L1 response: drain the late response, no update.
      @(negedge clk);
      wv = 1'b1; va = 32'h4000_1000; asid = 9'h005;
      @(negedge clk);
      wv = 1'b0;
      #1 check("fl_reqv", mem_if.mem_req_valid, 1'b1);
      mem_if.mem_req_ready = 1'b1;
      @(negedge clk);
      mem_if.mem_req_ready = 1'b0; flush = 1'b1;
      #1 check("fl_wait_busy", busy, 1'b1);
      check("fl_wait_ready", wr, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      #1 check("drain_busy", busy, 1'b1);
      check("drain_noreq", mem_if.mem_req_valid, 1'b0);
      @(negedge clk);
      mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_data = 32'h2000_00CF;
      #1 check("drain_upd", upd, 63'd0);
      @(negedge clk);
      mem_if.mem_rsp_valid = 1'b0;
      #1 check("post_drain_upd", upd, 63'd0);
      check("post_drain_fault", flt, 1'b0);
      check("post_drain_ready", wr, 1'b1);
      check("post_drain_busy", busy, 1'b0);

      // Flush in L1_REQ with ready high drops the request.
      @(negedge clk);
      wv = 1'b1;
      @(negedge clk);
      wv = 1'b0; flush = 1'b1; mem_if.mem_req_ready = 1'b1;
      #1 check("fl_req_memv", mem_if.mem_req_valid, 1'b0);
      @(negedge clk);
      flush = 1'b0; mem_if.mem_req_ready = 1'b0;
      #1 check("fl_req_busy", busy, 1'b0);

      // Flush beats a new request in IDLE.
      @(negedge clk);
      wv = 1'b1; flush = 1'b1;
      #1 check("fl_idle_ready", wr, 1'b0);
      @(negedge clk);
      wv = 1'b0; flush = 1'b0;
      #1 check("fl_idle_busy", busy, 1'b0);

      // Async reset in L0_WAIT, then a stale response after reset.
      @(negedge clk);
      wv = 1'b1; va = 32'h4000_1000; asid = 9'h005;
      @(negedge clk);
      wv = 1'b0; mem_if.mem_req_ready = 1'b1;
      @(negedge clk);
      mem_if.mem_req_ready = 1'b0;
      mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_data = 32'h0000_4C01;
      @(negedge clk);
      mem_if.mem_rsp_valid = 1'b0;
      #1 check("rw_l0_addr", mem_if.mem_req_addr, 34'h0_0001_3004);
      mem_if.mem_req_ready = 1'b1;
      @(negedge clk);
      mem_if.mem_req_ready = 1'b0;
      #1 check("rw_l0wait_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rw_busy",  busy, 1'b0);
      check("rw_memv",  mem_if.mem_req_valid, 1'b0);
      check("rw_upd",   upd, 63'd0);
      check("rw_fault", flt, 1'b0);
      check("rw_ready", wr, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_data = 32'h2000_00CF;
      @(negedge clk);
      mem_if.mem_rsp_valid = 1'b0;
      #1 check("rw_late_upd", upd, 63'd0);
      check("rw_late_busy", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
